// File: rtl/soc_ctrl_pll_reconfig_seq.sv
// soc_ctrl_pll_reconfig_seq
// Sequences safe reprogramming of one PLL-fed clock domain: gate the domain
// clock, assert the domain reset, program the PLL dividers, wait for a stable
// lock (bounded by a timeout), ungate the clock, then release the reset.
// After arst_i the same machine runs the power-on bring-up with the default
// dividers (WAIT_LOCK -> ENABLE -> RELEASE).
//
// Optional build macro: SOC_CTRL_PLL_SEQ_LOCK_STAT_EN
//   When defined, lock_cycles_o reports how many cycles the last successful
//   sequence spent in WAIT_LOCK (saturating at 16'hFFFF).
//
// Request handshake: a request transfers on the rising clk_i edge where
// req_valid_i && req_ready_o are both high. req_ready_o is a register that is
// high only while the machine sits in IDLE. The requester keeps req_valid_i
// and the dividers stable until that edge, so a request made while busy waits
// and is never dropped.
//
// All outputs except state_o are registers loaded from the next state, so each
// value is seen in the same cycle as the state it belongs to. state_o exposes
// the current FSM state for debug.
module soc_ctrl_pll_reconfig_seq #(
    parameter int unsigned REF_DIV_BW   = 4,
    parameter int unsigned FB_DIV_BW    = 12,
    parameter int unsigned DEF_REF_DIV  = 1,
    parameter int unsigned DEF_FB_DIV   = 1,
    parameter int unsigned GATE_CYCLES  = 8,
    parameter int unsigned LOCK_IGNORE  = 4,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned RST_DELAY    = 100
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [REF_DIV_BW-1:0] req_ref_div_i,
    input  logic [FB_DIV_BW-1:0]  req_fb_div_i,
    output logic [REF_DIV_BW-1:0] pll_ref_div_o,
    output logic [FB_DIV_BW-1:0]  pll_fb_div_o,
    input  logic                  pll_locked_i,
    output logic                  dom_clk_en_o,
    output logic                  dom_arst_n_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic                  err_clr_i,
`ifdef SOC_CTRL_PLL_SEQ_LOCK_STAT_EN
    output logic [15:0]           lock_cycles_o,
`endif
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GATE      = 3'd1,
        S_RESET     = 3'd2,
        S_PROGRAM   = 3'd3,
        S_WAIT_LOCK = 3'd4,
        S_ENABLE    = 3'd5,
        S_RELEASE   = 3'd6,
        S_FAIL      = 3'd7
    } state_t;

    // One counter serves both GATE and ENABLE; size it for the longer of the two.
    localparam int unsigned SEQ_MAX = (GATE_CYCLES > RST_DELAY) ? GATE_CYCLES : RST_DELAY;
    localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int unsigned WAIT_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned STAB_W  = $clog2(LOCK_STABLE + 1);

    localparam logic [SEQ_W-1:0]  GATE_LAST  = SEQ_W'(GATE_CYCLES - 1);
    localparam logic [SEQ_W-1:0]  DELAY_LAST = SEQ_W'(RST_DELAY - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(LOCK_TIMEOUT - 1);
    localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(LOCK_STABLE - 1);

    state_t state_q;
    state_t state_d;

    logic [SEQ_W-1:0]      seq_cnt_q;
    logic [WAIT_W-1:0]     wait_cnt_q;
    logic [STAB_W-1:0]     stable_q;
    logic [REF_DIV_BW-1:0] cap_ref_q;
    logic [FB_DIV_BW-1:0]  cap_fb_q;

    logic accept;
    logic div_illegal;
    logic ignore_done;
    logic lock_hit;
    logic timeout_hit;
    logic stay;

    logic                  clk_en_d;
    logic                  arst_n_d;
    logic [REF_DIV_BW-1:0] ref_div_d;
    logic [FB_DIV_BW-1:0]  fb_div_d;
    logic                  ready_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  err_d;

    assign accept      = (state_q == S_IDLE) && req_valid_i && req_ready_o;
    assign div_illegal = (req_ref_div_i == '0) || (req_fb_div_i == '0);
    assign ignore_done = (32'(wait_cnt_q) >= LOCK_IGNORE);
    // The cycle that brings the run of locked cycles up to LOCK_STABLE ends the wait.
    assign lock_hit    = ignore_done && pll_locked_i && (stable_q == STAB_LAST);
    assign timeout_hit = (wait_cnt_q == WAIT_LAST);
    assign stay        = (state_d == state_q);
    assign state_o     = state_q;

    // State register; reset lands in WAIT_LOCK to run the power-on bring-up.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= S_WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a lock on the last timeout cycle still counts as success.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept && !div_illegal) state_d = S_GATE;
            S_GATE:      if (seq_cnt_q == GATE_LAST) state_d = S_RESET;
            S_RESET:     state_d = S_PROGRAM;
            S_PROGRAM:   state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (lock_hit) begin
                    state_d = S_ENABLE;
                end else if (timeout_hit) begin
                    state_d = S_FAIL;
                end
            end
            S_ENABLE:    if (seq_cnt_q == DELAY_LAST) state_d = S_RELEASE;
            S_RELEASE:   state_d = S_IDLE;
            S_FAIL:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output values for the next cycle; IDLE keeps whatever the domain last had.
    always_comb begin
        clk_en_d  = dom_clk_en_o;
        arst_n_d  = dom_arst_n_o;
        ref_div_d = pll_ref_div_o;
        fb_div_d  = pll_fb_div_o;
        case (state_d)
            S_GATE: begin
                clk_en_d = 1'b0;
            end
            S_RESET, S_PROGRAM, S_WAIT_LOCK, S_FAIL: begin
                clk_en_d = 1'b0;
                arst_n_d = 1'b0;
            end
            S_ENABLE: begin
                clk_en_d = 1'b1;
                arst_n_d = 1'b0;
            end
            S_RELEASE: begin
                clk_en_d = 1'b1;
                arst_n_d = 1'b1;
            end
            default: begin
            end
        endcase
        if (state_q == S_PROGRAM) begin
            ref_div_d = cap_ref_q;
            fb_div_d  = cap_fb_q;
        end
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_RELEASE);
        // A new error outranks a clear arriving in the same cycle.
        err_d   = err_o;
        if ((state_d == S_FAIL) || (accept && div_illegal)) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            req_ready_o   <= 1'b0;
            pll_ref_div_o <= REF_DIV_BW'(DEF_REF_DIV);
            pll_fb_div_o  <= FB_DIV_BW'(DEF_FB_DIV);
            dom_clk_en_o  <= 1'b0;
            dom_arst_n_o  <= 1'b0;
            busy_o        <= 1'b1;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            req_ready_o   <= ready_d;
            pll_ref_div_o <= ref_div_d;
            pll_fb_div_o  <= fb_div_d;
            dom_clk_en_o  <= clk_en_d;
            dom_arst_n_o  <= arst_n_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
            err_o         <= err_d;
        end
    end

    // Sequencing counters; each restarts from 0 whenever its state is entered.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            seq_cnt_q  <= '0;
            wait_cnt_q <= '0;
            stable_q   <= '0;
        end else begin
            if (((state_q == S_GATE) || (state_q == S_ENABLE)) && stay) begin
                seq_cnt_q <= seq_cnt_q + SEQ_W'(1);
            end else begin
                seq_cnt_q <= '0;
            end
            if ((state_q == S_WAIT_LOCK) && stay) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                if (ignore_done) begin
                    stable_q <= pll_locked_i ? (stable_q + STAB_W'(1)) : '0;
                end
            end else begin
                wait_cnt_q <= '0;
                stable_q   <= '0;
            end
        end
    end

    // Hold the dividers of an accepted legal request until PROGRAM applies them.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cap_ref_q <= REF_DIV_BW'(DEF_REF_DIV);
            cap_fb_q  <= FB_DIV_BW'(DEF_FB_DIV);
        end else if (accept && !div_illegal) begin
            cap_ref_q <= req_ref_div_i;
            cap_fb_q  <= req_fb_div_i;
        end
    end

`ifdef SOC_CTRL_PLL_SEQ_LOCK_STAT_EN
    logic [31:0] lock_len;

    // Cycles spent in WAIT_LOCK including the cycle that found the lock.
    assign lock_len = 32'(wait_cnt_q) + 32'd1;

    // Lock-time statistic, captured on the transition into ENABLE.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            lock_cycles_o <= 16'h0000;
        end else if ((state_q == S_WAIT_LOCK) && (state_d == S_ENABLE)) begin
            lock_cycles_o <= (lock_len > 32'h0000_FFFF) ? 16'hFFFF : lock_len[15:0];
        end
    end
`endif

endmodule
